// File: rtl/ai_accel_pkg.sv
// Shared types and constants for the matrix-multiply command path.
// No logic; widths here fix the command/response datapath of the dispatcher and its FIFO.
// XLEN and TAG_WIDTH live here so that mm_cmd_t is one type shared by every user.
package ai_accel_pkg;

    localparam int XLEN      = 64;
    localparam int TAG_WIDTH = 4;

    localparam logic [2:0] DT_INT32 = 3'b010;
    localparam logic [2:0] DT_FP32  = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_FAULT  = 3'd4
    } dispatch_state_t;

    typedef enum logic [1:0] {
        RSP_OK        = 2'b00,
        RSP_BAD_DIMS  = 2'b01,
        RSP_BAD_DTYPE = 2'b10,
        RSP_TIMEOUT   = 2'b11
    } rsp_status_t;

    // dims = {8'h0, M, N, K}
    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic [2:0]           dtype;
        logic [31:0]          dims;
        logic [XLEN-1:0]      c;
        logic [XLEN-1:0]      b;
        logic [XLEN-1:0]      a;
    } mm_cmd_t;

    // A zero-sized dimension is never launched.
    function automatic logic dims_ok(input logic [31:0] dims);
        return (dims[23:16] != 8'd0) && (dims[15:8] != 8'd0) && (dims[7:0] != 8'd0);
    endfunction

    function automatic logic dtype_ok(input logic [2:0] dtype);
        return (dtype == DT_INT32) || (dtype == DT_FP32);
    endfunction

endpackage

// File: rtl/ai_cmd_fifo.sv
// Synchronous FIFO of mm_cmd_t with full/empty flags; head visible combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; push+pop together both apply.
// Ports: clk, rst_n, push_i/push_dat_i, pop_i/pop_dat_o, full_o, empty_o.
module ai_cmd_fifo
    import ai_accel_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push_i,
    input  mm_cmd_t push_dat_i,
    input  logic    pop_i,
    output mm_cmd_t pop_dat_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int PW = $clog2(DEPTH);

    mm_cmd_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o    = (count_q == (PW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];

    // Storage needs no reset: count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ai_matmul_dispatch.sv
// Matmul command front-end: queue, validate, launch, await done, return tagged response.
// Latency: push at T -> mm_enable at T+2; rsp_valid the cycle after mm_valid.
// Backpressure: cmd_ready = !full; RESP holds until rsp_ready, nothing launches meanwhile.
// Ports: cmd_* in (valid/ready), mm_* operands out + mm_result/mm_valid in,
//        rsp_* out (valid/ready), busy, sticky fault.
module ai_matmul_dispatch
    import ai_accel_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [XLEN-1:0]      cmd_a_addr,
    input  logic [XLEN-1:0]      cmd_b_addr,
    input  logic [XLEN-1:0]      cmd_c_addr,
    input  logic [31:0]          cmd_dims,
    input  logic [2:0]           cmd_dtype,
    input  logic [TAG_WIDTH-1:0] cmd_tag,
    output logic                 mm_enable,
    output logic [2:0]           mm_data_type,
    output logic [XLEN-1:0]      mm_a_addr,
    output logic [XLEN-1:0]      mm_b_addr,
    output logic [XLEN-1:0]      mm_c_addr,
    output logic [31:0]          mm_dimensions,
    input  logic [XLEN-1:0]      mm_result,
    input  logic                 mm_valid,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    output logic [1:0]           rsp_status,
    output logic [XLEN-1:0]      rsp_result,
    output logic                 busy,
    output logic                 fault
);

    // Watchdog counts 0..TIMEOUT_CYCLES-1; keep at least one bit when disabled.
    localparam int               WD_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    mm_cmd_t              push_cmd;
    mm_cmd_t              head_cmd;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;

    dispatch_state_t      state_q;
    logic [WD_W-1:0]      wdog_q;
    logic                 mm_enable_q;
    logic [2:0]           mm_dtype_q;
    logic [31:0]          mm_dims_q;
    logic [XLEN-1:0]      mm_a_q;
    logic [XLEN-1:0]      mm_b_q;
    logic [XLEN-1:0]      mm_c_q;
    logic                 rsp_valid_q;
    logic [TAG_WIDTH-1:0] rsp_tag_q;
    rsp_status_t          rsp_status_q;
    logic [XLEN-1:0]      rsp_result_q;
    logic                 fault_q;

    assign push_cmd = '{tag:   cmd_tag,
                        dtype: cmd_dtype,
                        dims:  cmd_dims,
                        c:     cmd_c_addr,
                        b:     cmd_b_addr,
                        a:     cmd_a_addr};

    // No pass-through when full, even if the FSM pops this cycle.
    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && !fifo_full;
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

    ai_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (fifo_push),
        .push_dat_i (push_cmd),
        .pop_i      (fifo_pop),
        .pop_dat_o  (head_cmd),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wdog_q       <= '0;
            mm_enable_q  <= 1'b0;
            mm_dtype_q   <= '0;
            mm_dims_q    <= '0;
            mm_a_q       <= '0;
            mm_b_q       <= '0;
            mm_c_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_status_q <= RSP_OK;
            rsp_result_q <= '0;
            fault_q      <= 1'b0;
        end else begin
            mm_enable_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        rsp_tag_q <= head_cmd.tag;
                        if (!dims_ok(head_cmd.dims)) begin
                            rsp_status_q <= RSP_BAD_DIMS;
                            rsp_result_q <= '0;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= ST_RESP;
                        end else if (!dtype_ok(head_cmd.dtype)) begin
                            rsp_status_q <= RSP_BAD_DTYPE;
                            rsp_result_q <= '0;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= ST_RESP;
                        end else begin
                            // Only place the operand registers ever change.
                            mm_dtype_q  <= head_cmd.dtype;
                            mm_dims_q   <= head_cmd.dims;
                            mm_a_q      <= head_cmd.a;
                            mm_b_q      <= head_cmd.b;
                            mm_c_q      <= head_cmd.c;
                            mm_enable_q <= 1'b1;
                            state_q     <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    wdog_q  <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (mm_valid) begin
                        rsp_status_q <= RSP_OK;
                        rsp_result_q <= mm_result;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
                    end else if ((TIMEOUT_CYCLES != 0) && (wdog_q == WD_MAX)) begin
                        rsp_status_q <= RSP_TIMEOUT;
                        rsp_result_q <= '0;
                        rsp_valid_q  <= 1'b1;
                        fault_q      <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= (rsp_status_q == RSP_TIMEOUT) ? ST_FAULT : ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    // Terminal until reset; the FIFO keeps filling but nothing pops.
                    state_q <= ST_FAULT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mm_enable     = mm_enable_q;
    assign mm_data_type  = mm_dtype_q;
    assign mm_dimensions = mm_dims_q;
    assign mm_a_addr     = mm_a_q;
    assign mm_b_addr     = mm_b_q;
    assign mm_c_addr     = mm_c_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_tag       = rsp_tag_q;
    assign rsp_status    = rsp_status_q;
    assign rsp_result    = rsp_result_q;
    assign fault         = fault_q;
    assign busy          = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_ai_matmul_dispatch.sv
// Directed bench for ai_matmul_dispatch with a scoreboard of expected responses.
// A behavioural matmul model answers each launch after model_lat cycles (0 = never).
// All outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_ai_matmul_dispatch;
    import ai_accel_pkg::*;

    localparam int TMO = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [XLEN-1:0]      cmd_a_addr = '0;
    logic [XLEN-1:0]      cmd_b_addr = '0;
    logic [XLEN-1:0]      cmd_c_addr = '0;
    logic [31:0]          cmd_dims = '0;
    logic [2:0]           cmd_dtype = '0;
    logic [TAG_WIDTH-1:0] cmd_tag = '0;
    logic                 mm_enable;
    logic [2:0]           mm_data_type;
    logic [XLEN-1:0]      mm_a_addr;
    logic [XLEN-1:0]      mm_b_addr;
    logic [XLEN-1:0]      mm_c_addr;
    logic [31:0]          mm_dimensions;
    logic [XLEN-1:0]      mm_result;
    logic                 mm_valid;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [TAG_WIDTH-1:0] rsp_tag;
    logic [1:0]           rsp_status;
    logic [XLEN-1:0]      rsp_result;
    logic                 busy;
    logic                 fault;

    always #5 clk = ~clk;

    ai_matmul_dispatch #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_a_addr    (cmd_a_addr),
        .cmd_b_addr    (cmd_b_addr),
        .cmd_c_addr    (cmd_c_addr),
        .cmd_dims      (cmd_dims),
        .cmd_dtype     (cmd_dtype),
        .cmd_tag       (cmd_tag),
        .mm_enable     (mm_enable),
        .mm_data_type  (mm_data_type),
        .mm_a_addr     (mm_a_addr),
        .mm_b_addr     (mm_b_addr),
        .mm_c_addr     (mm_c_addr),
        .mm_dimensions (mm_dimensions),
        .mm_result     (mm_result),
        .mm_valid      (mm_valid),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_tag       (rsp_tag),
        .rsp_status    (rsp_status),
        .rsp_result    (rsp_result),
        .busy          (busy),
        .fault         (fault)
    );

    typedef struct {
        logic [TAG_WIDTH-1:0] tag;
        logic [1:0]           st;
        logic [XLEN-1:0]      res;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   enable_cnt = 0;
    int   model_lat = 10;

    logic [226:0] ops_now;
    assign ops_now = {mm_data_type, mm_dimensions, mm_c_addr, mm_b_addr, mm_a_addr};

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (rst_n && mm_enable) enable_cnt++;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL rsp_unexpected: observed tag %0h status %0h, no response expected",
                       rsp_tag, rsp_status);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_tag", rsp_tag, mon_e.tag);
                check("rsp_status", rsp_status, mon_e.st);
                check("rsp_result", rsp_result, mon_e.res);
            end
        end
    end

    // Matmul model: answers with mm_result = C base; checks operands are held while busy.
    initial begin : mm_model
        logic         busy_m;
        int           cnt;
        logic [226:0] snap;
        busy_m    = 1'b0;
        cnt       = 0;
        snap      = '0;
        mm_valid  = 1'b0;
        mm_result = '0;
        forever begin
            @(negedge clk);
            mm_valid  = 1'b0;
            mm_result = '0;
            if (!rst_n) begin
                busy_m = 1'b0;
            end else if (busy_m) begin
                check("ops_stable", ops_now, snap);
                if (model_lat != 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        mm_valid  = 1'b1;
                        mm_result = mm_c_addr;
                        busy_m    = 1'b0;
                    end
                end
            end else if (mm_enable) begin
                busy_m = 1'b1;
                cnt    = model_lat;
                snap   = ops_now;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one command, waits (bounded) for acceptance, records its expected response.
    task automatic send(input logic [TAG_WIDTH-1:0] tag, input logic [2:0] dt,
                        input logic [31:0] dims, input logic [XLEN-1:0] c,
                        input logic [1:0] st, input bit expect_rsp);
        int waited;
        waited     = 0;
        cmd_valid  = 1'b1;
        cmd_tag    = tag;
        cmd_dtype  = dt;
        cmd_dims   = dims;
        cmd_a_addr = c ^ 64'h0000_00A0_0000_0000;
        cmd_b_addr = c ^ 64'h0000_00B0_0000_0000;
        cmd_c_addr = c;
        @(negedge clk);
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("cmd_accepted", cmd_ready, 1'b1);
        if (cmd_ready && expect_rsp) begin
            exp_q.push_back('{tag, st, (st == RSP_OK) ? c : '0});
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_enable(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mm_enable && n < 200);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 200);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check(name, {exp_q.size() == 0, busy}, 2'b10);
    endtask

    initial begin : timeout_guard
        #200000;
        $display("FAIL global_timeout: bench did not finish, %0d tests run", n_tests);
        $fatal(1, "bench time limit expired");
    end

    initial begin
        int n;
        int e0;

        // Reset state
        cyc(3);
        @(negedge clk);
        check("rst_ctrl", {cmd_ready, mm_enable, rsp_valid, busy, fault, rsp_tag, rsp_status},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00});
        check("rst_ops", ops_now, '0);
        check("rst_result", rsp_result, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(2);

        // 1: single INT32 command, latency and single enable pulse
        model_lat = 10;
        rsp_ready = 1'b1;
        e0 = enable_cnt;
        send(4'd3, DT_INT32, 32'h0002_0202, 64'h0000_1000, RSP_OK, 1'b1);
        wait_enable(n);
        check("t1_enable_lat", n, 2);
        check("t1_ops", ops_now, {DT_INT32, 32'h0002_0202, 64'h0000_1000,
                                  64'h0000_1000 ^ 64'h0000_00B0_0000_0000,
                                  64'h0000_1000 ^ 64'h0000_00A0_0000_0000});
        @(negedge clk);
        check("t1_enable_pulse", mm_enable, 1'b0);
        wait_rsp(n);
        check("t1_rsp_lat", n, 10);
        cyc(2);
        check("t1_enable_count", enable_cnt - e0, 1);
        check("t1_sb_empty", exp_q.size(), 0);

        // 2: fill the FIFO behind an in-flight command; order preserved
        model_lat = 12;
        e0 = enable_cnt;
        for (int i = 0; i < 5; i++) begin
            send(4'(4 + i), (i % 2 == 0) ? DT_INT32 : DT_FP32, 32'h0003_0405,
                 64'h0000_2000 + 64'(i) * 64'h100, RSP_OK, 1'b1);
        end
        @(negedge clk);
        check("t2_full_ready", {cmd_ready, busy}, 2'b01);
        @(posedge clk);
        #1;
        send(4'd9, DT_FP32, 32'h0001_0101, 64'h0000_2F00, RSP_OK, 1'b1);
        wait_drain("t2_drain");
        check("t2_enable_count", enable_cnt - e0, 6);
        cyc(1);

        // 3: validation failures are answered without launching
        e0 = enable_cnt;
        send(4'd10, DT_INT32, 32'h0001_0100, 64'h0000_3000, RSP_BAD_DIMS, 1'b1);
        send(4'd11, 3'b111,   32'h0001_0101, 64'h0000_3100, RSP_BAD_DTYPE, 1'b1);
        send(4'd12, DT_FP32,  32'h0000_0101, 64'h0000_3200, RSP_BAD_DIMS, 1'b1);
        send(4'd13, 3'b000,   32'h0000_0001, 64'h0000_3300, RSP_BAD_DIMS, 1'b1);
        wait_drain("t3_drain");
        check("t3_no_enable", enable_cnt - e0, 0);
        cyc(1);

        // 5: response held off; fields stable, no launch until handshake
        model_lat = 10;
        rsp_ready = 1'b0;
        send(4'd1, DT_INT32, 32'h0001_0101, 64'h0000_5000, RSP_OK, 1'b1);
        send(4'd2, DT_FP32,  32'h0002_0101, 64'h0000_6000, RSP_OK, 1'b1);
        wait_rsp(n);
        e0 = enable_cnt;
        for (int i = 0; i < 20; i++) begin
            check("t5_hold", {rsp_valid, rsp_tag, rsp_status, rsp_result},
                  {1'b1, 4'd1, 2'b00, 64'h0000_5000});
            @(negedge clk);
        end
        check("t5_no_enable", enable_cnt - e0, 0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_enable(n);
        check("t5_launch_after_hs", n, 3);
        wait_drain("t5_drain");
        cyc(1);

        // 6: reset during WAIT drops everything
        model_lat = 12;
        send(4'd7, DT_INT32, 32'h0001_0101, 64'h0000_7000, RSP_OK, 1'b1);
        send(4'd8, DT_INT32, 32'h0001_0101, 64'h0000_7100, RSP_OK, 1'b1);
        wait_enable(n);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t6_rst_ctrl", {cmd_ready, mm_enable, rsp_valid, busy, fault, rsp_tag, rsp_status},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'b00});
        check("t6_rst_ops", ops_now, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        e0 = enable_cnt;
        repeat (30) @(negedge clk);
        check("t6_quiet", {enable_cnt - e0 == 0, busy, rsp_valid, cmd_ready}, 4'b1001);
        cyc(1);

        // 4: watchdog timeout, then terminal FAULT
        model_lat = 0;
        e0 = enable_cnt;
        send(4'd14, DT_INT32, 32'h0001_0101, 64'h0000_8000, RSP_TIMEOUT, 1'b1);
        send(4'd15, DT_INT32, 32'h0001_0101, 64'h0000_8100, RSP_OK, 1'b0);
        wait_enable(n);
        wait_rsp(n);
        check("t4_timeout_lat", n, TMO + 1);
        check("t4_fault", fault, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            send(4'(i), DT_FP32, 32'h0001_0101, 64'h0000_9000, RSP_OK, 1'b0);
        end
        @(negedge clk);
        check("t4_fifo_full", cmd_ready, 1'b0);
        repeat (20) @(negedge clk);
        check("t4_no_launch", enable_cnt - e0, 1);
        check("t4_state", {busy, fault, rsp_valid}, 3'b110);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("t4_rst_clear", {fault, busy, cmd_ready}, 3'b001);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(3);

        check("final_sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
